// File: rtl/dsp_decim_pkg.sv
// dsp_decim_pkg: shared types and helpers for the multichannel CIC decimator
package dsp_decim_pkg;
  typedef enum logic {WARM, RUN} state_t;
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int clamp_ratio(input int r, input int nch);
    int lo;
    lo = (nch > 2) ? nch : 2;
    return (r < lo) ? lo : r;
  endfunction
endpackage

// File: rtl/decim_cic_mc_if.sv
// decim_cic_mc_if: valid/ready output stream carrying a sample and its channel index
interface decim_cic_mc_if #(
  parameter int DW = 16,
  parameter int CW = 1
);
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_chan;
  logic out_valid;
  logic out_ready;
  modport master (output out_data, out_chan, out_valid, input out_ready);
  modport slave (input out_data, out_chan, out_valid, output out_ready);
endinterface

// File: rtl/decim_out_fifo.sv
// decim_out_fifo: synchronous FIFO whose head entry is always visible on dout
module decim_out_fifo
  import dsp_decim_pkg::*;
#(
  parameter int W = 17,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic arst_n,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = cw(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);
  assign dout = mem[rp];
  // storage and pointers; a write into a full FIFO reuses the slot being popped
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      mem <= '{default: '0};
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) mem[wp] <= din;
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/decim_cic_mc.sv
// decim_cic_mc: multichannel CIC decimator, shared comb, output FIFO; DECIM_CIC_MC_SAT_EN enables saturation
module decim_cic_mc
  import dsp_decim_pkg::*;
#(
  parameter int NCH = 2,
  parameter int DW_IN = 12,
  parameter int DW_OUT = 16,
  parameter int N_STAGES = 5,
  parameter int RW = 56,
  parameter int RATIO_W = 11,
  parameter int RATIO_DEFAULT = 1625,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic arst_n,
  input  logic en,
  input  logic [NCH*DW_IN-1:0] data_in,
  input  logic [RATIO_W-1:0] ratio,
  input  logic ratio_load,
  input  logic [5:0] shift,
  decim_cic_mc_if.master stream,
  output logic busy,
  output logic overflow
);
  localparam int CW = cw(NCH);
  localparam int WW = cw(N_STAGES + 1);
  state_t state, state_nx;
  logic [RATIO_W-1:0] r_act, cnt;
  logic [WW-1:0] wcnt;
  logic [RW-1:0] integ [NCH][N_STAGES];
  logic [RW-1:0] snap [NCH];
  logic [RW-1:0] dly [NCH][N_STAGES];
  logic [RW-1:0] stg [N_STAGES+1];
  logic [CW-1:0] cb_idx;
  logic cb_act, keep, tick, push, pop, full, empty;
  logic [DW_OUT-1:0] res;
  logic [CW+DW_OUT-1:0] head;
  assign tick = en && !ratio_load && cnt == r_act - 1'b1;
  assign push = cb_act && keep;
  assign pop = stream.out_valid && stream.out_ready;
  assign stream.out_valid = !empty;
  assign {stream.out_chan, stream.out_data} = head;
  // state register
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) state <= WARM;
    else state <= state_nx;
  // restart on load; leave WARM on the N_STAGES-th tick
  always_comb begin
    state_nx = ratio_load ? WARM : (state == WARM && tick && wcnt == WW'(N_STAGES - 1)) ? RUN : state;
    busy = state == WARM;
  end
  // active ratio, en-cycle counter and warm-up tick counter
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      r_act <= RATIO_W'(RATIO_DEFAULT);
      cnt <= '0;
      wcnt <= '0;
    end else if (ratio_load) begin
      r_act <= RATIO_W'(clamp_ratio(int'(ratio), NCH));
      cnt <= '0;
      wcnt <= '0;
    end else begin
      if (en) cnt <= tick ? '0 : cnt + 1'b1;
      if (tick && state == WARM) wcnt <= wcnt + 1'b1;
    end
  // registered integrator cascade per channel; wraps modulo 2^RW
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) integ <= '{default: '0};
    else if (ratio_load) integ <= '{default: '0};
    else if (en)
      for (int c = 0; c < NCH; c++) begin
        integ[c][0] <= integ[c][0] + RW'($signed(data_in[c*DW_IN +: DW_IN]));
        for (int s = 1; s < N_STAGES; s++) integ[c][s] <= integ[c][s] + integ[c][s-1];
      end
  // snapshot on tick, then walk the channels through the shared comb one per clock
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      snap <= '{default: '0};
      keep <= 1'b0;
      cb_act <= 1'b0;
      cb_idx <= '0;
    end else if (ratio_load) begin
      snap <= '{default: '0};
      keep <= 1'b0;
      cb_act <= 1'b0;
      cb_idx <= '0;
    end else if (tick) begin
      for (int c = 0; c < NCH; c++) snap[c] <= integ[c][N_STAGES-1];
      keep <= state == RUN;
      cb_act <= 1'b1;
      cb_idx <= '0;
    end else if (cb_act) begin
      cb_idx <= cb_idx + 1'b1;
      cb_act <= cb_idx != CW'(NCH - 1);
    end
  // shared comb chain for the channel selected by the sequencer
  always_comb begin
    stg[0] = snap[cb_idx];
    for (int s = 0; s < N_STAGES; s++) stg[s+1] = stg[s] - dly[cb_idx][s];
  end
  // per-channel comb delay registers, advanced when that channel is processed
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) dly <= '{default: '0};
    else if (ratio_load) dly <= '{default: '0};
    else if (cb_act)
      for (int s = 0; s < N_STAGES; s++) dly[cb_idx][s] <= stg[s];
`ifdef DECIM_CIC_MC_SAT_EN
  logic signed [RW-1:0] sh;
  // clip when the bits above the output sign bit disagree with it
  always_comb begin
    sh = $signed(stg[N_STAGES]) >>> shift;
    res = (&sh[RW-1:DW_OUT-1] || ~|sh[RW-1:DW_OUT-1]) ? sh[DW_OUT-1:0] : {sh[RW-1], {(DW_OUT-1){~sh[RW-1]}}};
  end
`else
  assign res = DW_OUT'($signed(stg[N_STAGES]) >>> shift);
`endif
  // sticky drop flag: a RUN result found the FIFO full with no pop to make room
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) overflow <= 1'b0;
    else if (ratio_load) overflow <= 1'b0;
    else if (push && full && !pop) overflow <= 1'b1;
  decim_out_fifo #(.W(CW + DW_OUT), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .arst_n(arst_n),
    .clr(ratio_load),
    .push(push),
    .pop(pop),
    .din({cb_idx, res}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_decim_cic_mc.sv
// tb_decim_cic_mc: directed bench for decim_cic_mc with NCH=2, N_STAGES=3
module tb_decim_cic_mc;
  localparam int NCH = 2, DW_IN = 12, DW_OUT = 16, NS = 3, RATIO_W = 11;
  logic clk = 1'b0, arst_n = 1'b1, en = 1'b0, ratio_load = 1'b0, busy, overflow;
  logic [NCH*DW_IN-1:0] data_in = '0;
  logic [RATIO_W-1:0] ratio = '0;
  logic [5:0] shift = '0;
  int checks = 0, errors = 0;
  decim_cic_mc_if #(.DW(DW_OUT), .CW(1)) ob ();
  decim_cic_mc #(.NCH(NCH), .DW_IN(DW_IN), .DW_OUT(DW_OUT), .N_STAGES(NS), .RATIO_W(RATIO_W)) dut (
    .clk(clk), .arst_n(arst_n), .en(en), .data_in(data_in), .ratio(ratio), .ratio_load(ratio_load),
    .shift(shift), .stream(ob.master), .busy(busy), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input int r, input int sh, input int d0, input int d1);
    ratio = RATIO_W'(r);
    shift = 6'(sh);
    data_in = {DW_IN'(d1), DW_IN'(d0)};
    ratio_load = 1'b1;
    en = 1'b1;
    cyc();
    ratio_load = 1'b0;
  endtask
  task automatic next_out(output bit ok, output logic signed [DW_OUT-1:0] d, output logic c);
    ok = 1'b0;
    d = '0;
    c = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (ob.out_valid && ob.out_ready) begin
        ok = 1'b1;
        d = ob.out_data;
        c = ob.out_chan;
      end
      cyc();
    end
  endtask
  task automatic test_reset();
    #1 arst_n = 1'b0;
    #10;
    checks++; if (ob.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ob.out_valid); end
    checks++; if (ob.out_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", ob.out_data); end
    checks++; if (ob.out_chan !== 1'b0) begin errors++; $display("FAIL reset_chan got %b want 0", ob.out_chan); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
    @(negedge clk) arst_n = 1'b1;
    cyc();
  endtask
  task automatic test_dc();
    bit ok;
    logic signed [DW_OUT-1:0] d;
    logic c;
    int n, e;
    ob.out_ready = 1'b1;
    load(4, 6, 1000, 1000);
    n = 0;
    while (!ob.out_valid && n < 100) begin cyc(); n++; end
    checks++; if (n != 17) begin errors++; $display("FAIL dc_latency got %0d want 17", n); end
    for (int k = 0; k < 6; k++) begin
      next_out(ok, d, c);
      checks++; if (!ok || d !== 16'sd1000) begin errors++; $display("FAIL dc_data%0d got %0d (ok=%b) want 1000", k, d, ok); end
      checks++; if (c !== k[0]) begin errors++; $display("FAIL dc_chan%0d got %0d want %0d", k, c, k % 2); end
    end
    load(4, 6, 500, -300);
    for (int k = 0; k < 4; k++) begin
      e = k[0] ? -300 : 500;
      next_out(ok, d, c);
      checks++; if (!ok || d !== DW_OUT'(e)) begin errors++; $display("FAIL mix_data%0d got %0d (ok=%b) want %0d", k, d, ok, e); end
      checks++; if (c !== k[0]) begin errors++; $display("FAIL mix_chan%0d got %0d want %0d", k, c, k % 2); end
    end
  endtask
  task automatic test_overflow();
    bit ok;
    logic signed [DW_OUT-1:0] d;
    logic c;
    ob.out_ready = 1'b0;
    load(4, 6, 1000, 1000);
    repeat (32) cyc();
    checks++; if (overflow !== 1'b0 || ob.out_valid !== 1'b1) begin errors++; $display("FAIL full_no_ovf got ovf=%b valid=%b want 0/1", overflow, ob.out_valid); end
    checks++; if (ob.out_chan !== 1'b0 || ob.out_data !== 16'd1000) begin errors++; $display("FAIL held_head got %0d/%0d want 0/1000", ob.out_chan, ob.out_data); end
    cyc();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    en = 1'b0;
    cyc();
    cyc();
    ob.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      next_out(ok, d, c);
      checks++; if (!ok || d !== 16'sd1000 || c !== k[0]) begin errors++; $display("FAIL drain%0d got %0d ch %0d (ok=%b) want 1000 ch %0d", k, d, c, ok, k % 2); end
    end
    checks++; if (ob.out_valid !== 1'b0) begin errors++; $display("FAIL drained_valid got %b want 0", ob.out_valid); end
  endtask
  task automatic test_back_to_back();
    int n;
    ob.out_ready = 1'b0;
    load(4, 6, 1000, 1000);
    repeat (32) cyc();
    ob.out_ready = 1'b1;
    en = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (ob.out_valid && ob.out_ready) n++;
      cyc();
    end
    checks++; if (n != 10) begin errors++; $display("FAIL b2b_count got %0d want 10", n); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got %b want 0", overflow); end
  endtask
  task automatic test_reload();
    int n;
    ob.out_ready = 1'b0;
    load(4, 6, 1000, 1000);
    repeat (36) cyc();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL pre_reload_ovf got %b want 1", overflow); end
    load(4, 6, 1000, 1000);
    checks++; if (ob.out_valid !== 1'b0) begin errors++; $display("FAIL reload_valid got %b want 0", ob.out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reload_ovf got %b want 0", overflow); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reload_busy got %b want 1", busy); end
    n = 0;
    while (busy && n < 100) begin cyc(); n++; end
    checks++; if (n != 12) begin errors++; $display("FAIL reload_warm got %0d want 12", n); end
  endtask
  task automatic test_clamp();
    bit ok;
    logic signed [DW_OUT-1:0] d;
    logic c;
    int n;
    ob.out_ready = 1'b1;
    load(1, 3, 1000, 1000);
    n = 0;
    while (busy && n < 100) begin cyc(); n++; end
    checks++; if (n != 6) begin errors++; $display("FAIL clamp_warm got %0d want 6", n); end
    next_out(ok, d, c);
    checks++; if (!ok || d !== 16'sd1000 || c !== 1'b0) begin errors++; $display("FAIL clamp_data got %0d ch %0d (ok=%b) want 1000 ch 0", d, c, ok); end
  endtask
  task automatic test_sat();
    bit ok;
    logic signed [DW_OUT-1:0] d;
    logic c;
`ifdef DECIM_CIC_MC_SAT_EN
    int e = 32767;
`else
    int e = -64;
`endif
    ob.out_ready = 1'b1;
    load(4, 0, 2047, 2047);
    for (int k = 0; k < 2; k++) begin
      next_out(ok, d, c);
      checks++; if (!ok || d !== DW_OUT'(e) || c !== k[0]) begin errors++; $display("FAIL sat%0d got %0d ch %0d (ok=%b) want %0d ch %0d", k, d, c, ok, e, k % 2); end
    end
  endtask
  task automatic test_async_reset();
    int n;
    bit seen;
    ob.out_ready = 1'b1;
    load(4, 6, 1000, 1000);
    repeat (16) cyc();
    arst_n = 1'b0;
    #1;
    checks++; if (ob.out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL arst_state got valid=%b busy=%b want 0/1", ob.out_valid, busy); end
    @(negedge clk) arst_n = 1'b1;
    n = 0;
    seen = 1'b0;
    while (busy && n < 6000) begin
      cyc();
      n++;
      if (ob.out_valid) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL arst_output got valid during warm want none"); end
    checks++; if (n != 4875) begin errors++; $display("FAIL arst_ratio got %0d warm cycles want 4875", n); end
  endtask
  initial begin
    ob.out_ready = 1'b0;
    test_reset();
    test_dc();
    test_overflow();
    test_back_to_back();
    test_reload();
    test_clamp();
    test_sat();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
